// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command arbiter: command encodings
// {cs_n, ras_n, cas_n, we_n}, bus widths and the arbiter state type.
package sdram_pkg;

   localparam int unsigned CmdWidth  = 4;
   localparam int unsigned AddrWidth = 12;
   localparam int unsigned BankWidth = 2;

   localparam logic [CmdWidth-1:0] CmdNop  = 4'b0111;
   localparam logic [CmdWidth-1:0] CmdPre  = 4'b0010;
   localparam logic [CmdWidth-1:0] CmdAref = 4'b0001;
   localparam logic [CmdWidth-1:0] CmdAct  = 4'b0011;
   localparam logic [CmdWidth-1:0] CmdWr   = 4'b0100;
   localparam logic [CmdWidth-1:0] CmdRd   = 4'b0101;
   localparam logic [CmdWidth-1:0] CmdMrs  = 4'b0000;

   typedef enum logic [2:0] {
      StInit  = 3'd0,
      StArbit = 3'd1,
      StAref  = 3'd2,
      StWrite = 3'd3,
      StRead  = 3'd4
   } state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of the init/refresh/write/read request paths and the shared SDRAM
// command bus. The arbiter takes the slave view; requesters take the master.
interface sdram_arbiter_if;
   import sdram_pkg::*;

   logic                 flag_init_end;
   logic [CmdWidth-1:0]  init_cmd;
   logic [AddrWidth-1:0] init_addr;

   logic                 ref_req;
   logic [CmdWidth-1:0]  ref_cmd;
   logic [AddrWidth-1:0] ref_addr;
   logic [BankWidth-1:0] ref_bank;
   logic                 flag_ref_end;
   logic                 ref_en;

   logic                 wr_req;
   logic [CmdWidth-1:0]  wr_cmd;
   logic [AddrWidth-1:0] wr_addr;
   logic [BankWidth-1:0] wr_bank;
   logic                 flag_wr_end;
   logic                 wr_en;

   logic                 rd_req;
   logic [CmdWidth-1:0]  rd_cmd;
   logic [AddrWidth-1:0] rd_addr;
   logic [BankWidth-1:0] rd_bank;
   logic                 flag_rd_end;
   logic                 rd_en;

   logic [CmdWidth-1:0]  sdram_cmd;
   logic [AddrWidth-1:0] sdram_addr;
   logic [BankWidth-1:0] sdram_bank;
   logic                 arb_busy;

   modport slave (
      input  flag_init_end, init_cmd, init_addr,
      input  ref_req, ref_cmd, ref_addr, ref_bank, flag_ref_end,
      input  wr_req, wr_cmd, wr_addr, wr_bank, flag_wr_end,
      input  rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
      output ref_en, wr_en, rd_en,
      output sdram_cmd, sdram_addr, sdram_bank, arb_busy
   );

   modport master (
      output flag_init_end, init_cmd, init_addr,
      output ref_req, ref_cmd, ref_addr, ref_bank, flag_ref_end,
      output wr_req, wr_cmd, wr_addr, wr_bank, flag_wr_end,
      output rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
      input  ref_en, wr_en, rd_en,
      input  sdram_cmd, sdram_addr, sdram_bank, arb_busy
   );

endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: after init completes, grants the bus to refresh,
// write or read by fixed priority and muxes the owner's command onto it.
// Optional macro SDRAM_ARB_RR_EN makes write/read ties alternate round-robin.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter logic [CmdWidth-1:0] NOP = CmdNop
) (
   input logic            clk,
   input logic            rst,
   sdram_arbiter_if.slave bus
);

   state_e state_q, state_d;
   logic   ref_en_q, ref_en_d;
   logic   wr_en_q, wr_en_d;
   logic   rd_en_q, rd_en_d;
   logic   wr_wins;
   logic   grant_ref, grant_wr, grant_rd;

   // Grants are only decoded in ARBIT; refresh always pre-empts write/read.
   assign grant_ref = (state_q == StArbit) && bus.ref_req;
   assign grant_wr  = (state_q == StArbit) && !bus.ref_req && bus.wr_req &&
                      (!bus.rd_req || wr_wins);
   assign grant_rd  = (state_q == StArbit) && !bus.ref_req && bus.rd_req && !grant_wr;

`ifdef SDRAM_ARB_RR_EN
   logic rr_wr_q, rr_wr_d;

   assign wr_wins = rr_wr_q;

   // Whichever of write/read was granted last loses the next tie.
   always_comb begin
      rr_wr_d = rr_wr_q;
      if (grant_wr) begin
         rr_wr_d = 1'b0;
      end else if (grant_rd) begin
         rr_wr_d = 1'b1;
      end
   end

   // Tie-break pointer register, favouring write out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_wr_q <= 1'b1;
      end else begin
         rr_wr_q <= rr_wr_d;
      end
   end
`else
   assign wr_wins = 1'b1;
`endif

   // Next-state and one-shot enable decode.
   always_comb begin
      state_d  = state_q;
      ref_en_d = 1'b0;
      wr_en_d  = 1'b0;
      rd_en_d  = 1'b0;
      unique case (state_q)
         StInit: begin
            if (bus.flag_init_end) state_d = StArbit;
         end
         StArbit: begin
            if (grant_ref) begin
               state_d  = StAref;
               ref_en_d = 1'b1;
            end else if (grant_wr) begin
               state_d = StWrite;
               wr_en_d = 1'b1;
            end else if (grant_rd) begin
               state_d = StRead;
               rd_en_d = 1'b1;
            end
         end
         StAref: begin
            if (bus.flag_ref_end) state_d = StArbit;
         end
         StWrite: begin
            if (bus.flag_wr_end) state_d = StArbit;
         end
         StRead: begin
            if (bus.flag_rd_end) state_d = StArbit;
         end
         default: state_d = StInit;
      endcase
   end

   // State and enable registers; enables line up with the first granted cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StInit;
         ref_en_q <= 1'b0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ref_en_q <= ref_en_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
      end
   end

   assign bus.ref_en   = ref_en_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.arb_busy = (state_q != StArbit);

   // Bus mux: the current owner's command/address/bank, NOP when idle.
   always_comb begin
      bus.sdram_cmd  = NOP;
      bus.sdram_addr = '0;
      bus.sdram_bank = '0;
      unique case (state_q)
         StInit: begin
            bus.sdram_cmd  = bus.init_cmd;
            bus.sdram_addr = bus.init_addr;
         end
         StAref: begin
            bus.sdram_cmd  = bus.ref_cmd;
            bus.sdram_addr = bus.ref_addr;
            bus.sdram_bank = bus.ref_bank;
         end
         StWrite: begin
            bus.sdram_cmd  = bus.wr_cmd;
            bus.sdram_addr = bus.wr_addr;
            bus.sdram_bank = bus.wr_bank;
         end
         StRead: begin
            bus.sdram_cmd  = bus.rd_cmd;
            bus.sdram_addr = bus.rd_addr;
            bus.sdram_bank = bus.rd_bank;
         end
         default: begin
            bus.sdram_cmd  = NOP;
            bus.sdram_addr = '0;
            bus.sdram_bank = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a table of per-cycle vectors with expected state
// and enables, checked through an expected-result queue, then a hand-written
// write/read tie sequence checked by a grant-order scoreboard.
module tb_sdram_arbiter;
   import sdram_pkg::*;

`ifdef SDRAM_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   localparam logic [2:0] EnNone = 3'b000;
   localparam logic [2:0] EnRef  = 3'b100;
   localparam logic [2:0] EnWr   = 3'b010;
   localparam logic [2:0] EnRd   = 3'b001;

   typedef struct {
      logic       rst;
      logic       fi;
      logic       rq_ref;
      logic       rq_wr;
      logic       rq_rd;
      logic       f_ref;
      logic       f_wr;
      logic       f_rd;
      state_e     st;
      logic [2:0] en;
   } vec_t;

   typedef struct {
      state_e     st;
      logic [2:0] en;
   } exp_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   mon_on = 1'b0;

   vec_t       vecs[$];
   exp_t       exp_q[$];
   logic [2:0] grant_q[$];

   sdram_arbiter_if bus ();

   sdram_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic fi, input logic qf, input logic qw,
                               input logic qr, input logic ff, input logic fw, input logic fr,
                               input state_e st, input logic [2:0] en);
      vec_t v;
      v.rst = r;  v.fi = fi;
      v.rq_ref = qf; v.rq_wr = qw; v.rq_rd = qr;
      v.f_ref = ff; v.f_wr = fw; v.f_rd = fr;
      v.st = st; v.en = en;
      return v;
   endfunction

   function automatic logic [3:0] exp_cmd(input state_e st);
      case (st)
         StInit:  return 4'b0001;
         StAref:  return 4'b0010;
         StWrite: return 4'b0100;
         StRead:  return 4'b0101;
         default: return 4'b0111;
      endcase
   endfunction

   function automatic logic [11:0] exp_addr(input state_e st);
      case (st)
         StInit:  return 12'h111;
         StAref:  return 12'h222;
         StWrite: return 12'h333;
         StRead:  return 12'h444;
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [1:0] exp_bank(input state_e st);
      case (st)
         StAref:  return 2'b01;
         StWrite: return 2'b10;
         StRead:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   task automatic drive(input vec_t v);
      rst               = v.rst;
      bus.flag_init_end = v.fi;
      bus.ref_req       = v.rq_ref;
      bus.wr_req        = v.rq_wr;
      bus.rd_req        = v.rq_rd;
      bus.flag_ref_end  = v.f_ref;
      bus.flag_wr_end   = v.f_wr;
      bus.flag_rd_end   = v.f_rd;
   endtask

   task automatic step(input vec_t v, input int idx);
      exp_t e;
      drive(v);
      e.st = v.st;
      e.en = v.en;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_cmd", idx), 32'(bus.sdram_cmd), 32'(exp_cmd(e.st)));
      check($sformatf("v%0d_addr", idx), 32'(bus.sdram_addr), 32'(exp_addr(e.st)));
      check($sformatf("v%0d_bank", idx), 32'(bus.sdram_bank), 32'(exp_bank(e.st)));
      check($sformatf("v%0d_busy", idx), 32'(bus.arb_busy), 32'(e.st != StArbit));
      check($sformatf("v%0d_en", idx), 32'({bus.ref_en, bus.wr_en, bus.rd_en}), 32'(e.en));
   endtask

   // Grant-order monitor: every enable pulse must match the next expected grant.
   always @(negedge clk) begin
      if (mon_on && (bus.ref_en || bus.wr_en || bus.rd_en)) begin
         check("grant_onehot", 32'($countones({bus.ref_en, bus.wr_en, bus.rd_en})), 32'd1);
         if (grant_q.size() == 0) begin
            check("grant_unexpected", 32'({bus.ref_en, bus.wr_en, bus.rd_en}), 32'd0);
         end else begin
            check("grant_order", 32'({bus.ref_en, bus.wr_en, bus.rd_en}),
                  32'(grant_q.pop_front()));
         end
      end
   end

   initial begin
      bus.init_cmd  = 4'b0001; bus.init_addr = 12'h111;
      bus.ref_cmd   = 4'b0010; bus.ref_addr  = 12'h222; bus.ref_bank = 2'b01;
      bus.wr_cmd    = 4'b0100; bus.wr_addr   = 12'h333; bus.wr_bank  = 2'b10;
      bus.rd_cmd    = 4'b0101; bus.rd_addr   = 12'h444; bus.rd_bank  = 2'b11;

      //                 rst fi qf qw qr ff fw fr  state    en
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, StInit,  EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, StInit,  EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, StInit,  EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, StInit,  EnNone));
      vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, StArbit, EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, StAref,  EnRef));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, StAref,  EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, StAref,  EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 0, StArbit, EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, StWrite, EnWr));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, StWrite, EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, StWrite, EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, StArbit, EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, RrEn ? StRead : StWrite, RrEn ? EnRd : EnWr));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, StArbit, EnNone));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, StRead,  EnRd));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, StRead,  EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, StRead,  EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, StRead,  EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, StArbit, EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, StWrite, EnWr));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, StArbit, EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, StWrite, EnWr));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, StWrite, EnNone));
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, StInit,  EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, StInit,  EnNone));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, StInit,  EnNone));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, StArbit, EnNone));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, StWrite, EnWr));

      foreach (vecs[i]) step(vecs[i], i);

      // Write/read held high continuously from a fresh reset.
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, StInit, EnNone), 100);
      step(mk(0, 1, 0, 0, 0, 0, 0, 0, StArbit, EnNone), 101);
      for (int g = 0; g < 4; g++) begin
         grant_q.push_back((RrEn && (g % 2 == 1)) ? EnRd : EnWr);
      end
      mon_on = 1'b1;
      for (int g = 0; g < 4; g++) begin
         drive(mk(0, 0, 0, 1, 1, 0, 0, 0, StArbit, EnNone));
         @(posedge clk);
         #1;
         drive(mk(0, 0, 0, 1, 1, 0, 1, 1, StArbit, EnNone));
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      mon_on = 1'b0;
      check("grants_left", 32'(grant_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
